alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_arbiter_alu.sv | 35 +++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode encodings and the
// transaction FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU datapath: add, sub, and 8-bit fixed-point multiply
// (bits [11:4] of the 16-bit-truncated product); unknown opcodes flag err_o.
module ALU
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o,
    output logic         err_o
);

    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] prod16;

    // A 16-bit multiply is already the full product truncated mod 2^16.
    assign a16    = 16'(a_i);
    assign b16    = 16'(b_i);
    assign prod16 = a16 * b16;

    always_comb begin
        y_o   = '0;
        err_o = 1'b0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_MUL: y_o = W'((prod16 >> 4) & 16'h00FF);
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters; one
// transaction in flight, IDLE -> EXEC -> RESP with a held response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3*NUM_REQ-1:0] req_op,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    arb_state_e   state_q;
    logic [1:0]   ptr_q;
    logic [1:0]   ptr_d;
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [1:0]   id_q;
    logic         rsp_valid_q;
    logic [W-1:0] rsp_data_q;
    logic [1:0]   rsp_id_q;
    logic         rsp_err_q;

    logic [2:0]   op_arr [NUM_REQ];
    logic [W-1:0] a_arr  [NUM_REQ];
    logic [W-1:0] b_arr  [NUM_REQ];

    logic         grant_vld;
    logic [1:0]   grant_idx;
    logic [1:0]   idx;

    logic [W-1:0] alu_y;
    logic         alu_err;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            op_arr[i] = req_op[3*i +: 3];
            a_arr[i]  = req_a[W*i +: W];
            b_arr[i]  = req_b[W*i +: W];
        end
    end

    // First valid requester at or after ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 2'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign ptr_d = (grant_idx == 2'(NUM_REQ - 1)) ? '0 : grant_idx + 2'd1;

    always_comb begin
        req_ready = '0;
        if (!rst && state_q == ST_IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    ALU #(
        .W(W)
    ) u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y),
        .err_o(alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        op_q    <= op_arr[grant_idx];
                        a_q     <= a_arr[grant_idx];
                        b_q     <= b_arr[grant_idx];
                        id_q    <= grant_idx;
                        ptr_q   <= ptr_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= alu_y;
                    rsp_err_q   <= alu_err;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus randomized
// traffic checked against an arithmetic reference model.
module tb_alu_arbiter;

    localparam int unsigned N = 3;
    localparam int unsigned W = 16;

    typedef struct {
        int unsigned id;
        logic [15:0] data;
        logic        err;
        int unsigned due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ(N),
        .W      (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .busy     (busy)
    );

    bit          pend_v  [N];
    logic [2:0]  pend_op [N];
    logic [15:0] pend_a  [N];
    logic [15:0] pend_b  [N];
    bit          gflag   [N];
    bit          refill;
    bit          rnd_mode;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned model_ptr;
    bit          model_idle = 1'b1;
    bit          rst_pend;
    bit          log_en;
    int unsigned grant_log[$];
    exp_t        q[$];
    logic [15:0] last_data;
    logic [1:0]  last_id;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int unsigned id, input logic [2:0] op,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input int unsigned due);
        exp_t        e;
        int unsigned p;
        e.id   = id;
        e.due  = due;
        e.err  = 1'b0;
        e.data = 16'h0;
        p      = 32'(a) * 32'(b);
        case (op)
            3'd0:    e.data = 16'((32'(a) + 32'(b)) % 65536);
            3'd1:    e.data = 16'((32'(a) + 65536 - 32'(b)) % 65536);
            3'd2:    e.data = 16'(((p % 65536) / 16) % 256);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic new_req(input int i);
        pend_v[i]  = 1'b1;
        pend_op[i] = ($urandom_range(3) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
        pend_a[i]  = 16'($urandom);
        pend_b[i]  = 16'($urandom);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend_v[i];
            req_op[3*i +: 3]   = pend_op[i];
            req_a[W*i +: W]    = pend_a[i];
            req_b[W*i +: W]    = pend_b[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gflag[i]) begin
                gflag[i] = 1'b0;
                if (refill) new_req(i);
                else pend_v[i] = 1'b0;
            end else if (rnd_mode) begin
                if (!pend_v[i] && $urandom_range(3) == 0) new_req(i);
                else if (pend_v[i] && $urandom_range(31) == 0) pend_v[i] = 1'b0;
            end
        end
        if (rnd_mode) rsp_ready = ($urandom_range(3) != 0);
        drive();
    endtask

    task automatic send(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        pend_v[i]  = 1'b1;
        pend_op[i] = op;
        pend_a[i]  = a;
        pend_b[i]  = b;
        drive();
        for (int t = 0; t < 40 && pend_v[i]; t++) step();
        if (pend_v[i]) chk("send_timeout", 32'(i), 32'hFFFF);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && !(q.size() == 0 && model_idle); t++) step();
        if (!(q.size() == 0 && model_idle)) chk("drain_timeout", 32'(q.size()), 0);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        logic [N-1:0] exp_ready;
        int           g;
        int unsigned  ix;
        bit           exp_v;
        bit           hs;
        exp_t         e;
        cyc++;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            q.delete();
            model_ptr  = 0;
            model_idle = 1'b1;
            rst_pend   = 1'b1;
            for (int i = 0; i < N; i++) gflag[i] = 1'b0;
        end else begin
            if (rst_pend) begin
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_data", 32'(rsp_data), 0);
                chk("rst_rsp_id", 32'(rsp_id), 0);
                chk("rst_rsp_err", 32'(rsp_err), 0);
                chk("rst_busy", 32'(busy), 0);
                rst_pend = 1'b0;
            end
            exp_ready = '0;
            g = -1;
            if (model_idle) begin
                for (int k = 0; k < N; k++) begin
                    ix = (model_ptr + k) % N;
                    if (g < 0 && req_valid[ix]) g = int'(ix);
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(!model_idle));

            exp_v = (q.size() > 0) && (cyc >= q[0].due);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            hs = 1'b0;
            if (rsp_valid && exp_v) begin
                chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
                chk("rsp_id", 32'(rsp_id), q[0].id);
                chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
                if (rsp_ready) begin
                    last_data = rsp_data;
                    last_id   = rsp_id;
                    last_err  = rsp_err;
                    void'(q.pop_front());
                    hs = 1'b1;
                end
            end

            if (g >= 0) begin
                e = model(int'(g), req_op[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W], cyc + 2);
                q.push_back(e);
                model_idle = 1'b0;
                model_ptr  = (int'(g) + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    gflag[i] = 1'b1;
                    if (log_en) grant_log.push_back(i);
                end
            end
            if (hs) model_idle = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        rsp_ready = 1'b0;
        refill    = 1'b0;
        rnd_mode  = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0; pend_op[i] = '0; pend_a[i] = '0; pend_b[i] = '0; gflag[i] = 1'b0;
        end
        drive();
        step();
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;

        send(0, 3'b000, 16'h0003, 16'h0005);
        drain();
        chk("add_data", 32'(last_data), 32'h0008);
        chk("add_id", 32'(last_id), 0);
        chk("add_err", 32'(last_err), 0);

        send(0, 3'b001, 16'h0000, 16'h0001);
        drain();
        chk("sub_wrap", 32'(last_data), 32'hFFFF);

        send(0, 3'b010, 16'h0030, 16'h0020);
        drain();
        chk("mul_fx", 32'(last_data), 32'h0060);

        send(1, 3'b101, 16'h1234, 16'h5678);
        drain();
        chk("bad_op_data", 32'(last_data), 0);
        chk("bad_op_err", 32'(last_err), 1);
        chk("bad_op_id", 32'(last_id), 1);

        // Fairness: all requesters held valid from reset
        do_reset();
        refill = 1'b1;
        for (int i = 0; i < N; i++) new_req(i);
        drive();
        grant_log.delete();
        log_en = 1'b1;
        for (int t = 0; t < 60 && grant_log.size() < 6; t++) step();
        log_en = 1'b0;
        refill = 1'b0;
        clear_reqs();
        drain();
        for (int k = 0; k < 6; k++)
            chk("fair_order", (k < grant_log.size()) ? grant_log[k] : 32'd99, 32'(k % 3));

        // Backpressure: response held with a competing request pending
        rsp_ready = 1'b0;
        send(2, 3'b000, 16'($urandom), 16'($urandom));
        new_req(0);
        drive();
        for (int t = 0; t < 10 && !rsp_valid; t++) step();
        for (int t = 0; t < 5; t++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        for (int t = 0; t < 20 && pend_v[0]; t++) step();
        clear_reqs();
        drain();

        // Reset while a transaction is in EXEC
        new_req(1);
        new_req(2);
        drive();
        for (int t = 0; t < 20 && pend_v[1] && pend_v[2]; t++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        new_req(0);
        drive();
        grant_log.delete();
        log_en = 1'b1;
        for (int t = 0; t < 20 && grant_log.size() < 1; t++) step();
        log_en = 1'b0;
        chk("reset_grant", (grant_log.size() > 0) ? grant_log[0] : 32'd99, 0);
        clear_reqs();
        drain();

        // Randomized traffic with drops, backpressure and operand churn
        rnd_mode = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        clear_reqs();
        rsp_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
